sd_emmc_io_drv: RTL and testbench
=================================

SD_EMMC_IO_DRV -- requirements
Module: sd_emmc_io_drv

Interface
REQ-001 Parameter DATA_WIDTH, default 4, lane count (legal 1..8; 1 = CMD line, 4/8 = DAT bus) SHALL be supported.
REQ-002 Parameter DLY_STAGES, default 0, extra output pipeline registers (legal 0..3) SHALL be supported.
REQ-003 Parameter PARK_CYCLES, default 1, cycles of driven-high after drive ends (legal 0..15) SHALL be supported.
REQ-004 clk_i  input  1  SHALL be the single block clock; all flops rising-edge.
REQ-005 rst_n_i  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-006 do_i  input  DATA_WIDTH  SHALL be data to drive onto pads.
REQ-007 oe_i  input  1  SHALL be the drive request, 1 = controller owns the bus.
REQ-008 od_mode_i  input  1  SHALL select open-drain (1) or push-pull (0) signalling, sampled every cycle.
REQ-009 di_o  output  DATA_WIDTH  SHALL be the registered pad input sample.
REQ-010 busy_o  output  1  SHALL be 1 whenever the FSM is not IDLE.
REQ-011 dat_pad  inout  DATA_WIDTH  SHALL connect directly to top-level pads.

Function
REQ-012 The FSM SHALL have states IDLE (pads released), DRIVE (pads driven with data), PARK (pads driven all-ones).
REQ-013 IDLE->DRIVE SHALL occur on the first cycle oe_i=1 is sampled.
REQ-014 DRIVE->PARK SHALL occur when oe_i=0 is sampled, od_mode_i=0 and PARK_CYCLES>0; otherwise DRIVE->IDLE.
REQ-015 PARK SHALL last exactly PARK_CYCLES cycles via a 4-bit down-counter loaded on entry, then go to IDLE.
REQ-016 oe_i=1 sampled in PARK SHALL abort park and enter DRIVE next cycle; the counter is cleared.
REQ-017 Push-pull: lane n SHALL be driven with the data bit in DRIVE, with 1 in PARK, and released in IDLE.
REQ-018 Open-drain: lane n SHALL be driven low only when in DRIVE and data bit = 0, otherwise released; PARK is never entered.
REQ-019 Pad data and per-lane enable SHALL be registered in a final output flop stage.
REQ-020 Latency from do_i/oe_i sample to pad change SHALL be 1 + DLY_STAGES cycles; data and enable SHALL pass through identical delay so they stay aligned.
REQ-021 The FSM SHALL evaluate at the input side; the delay line SHALL carry the per-lane enable and value, so PARK and release timing also shift by DLY_STAGES.
REQ-022 di_o SHALL be pad value registered once, 1-cycle latency, sampled regardless of state; while driving it SHALL reflect the driven value.
REQ-023 A od_mode_i change mid-DRIVE SHALL take effect on the next sampled cycle without leaving DRIVE.
REQ-024 Pads SHALL never be driven in both directions: a released lane presents high-Z only.

Reset
REQ-025 On rst_n_i=0: FSM SHALL be IDLE, park counter 0, all delay and output flops enable=0 and data=1, di_o = all-ones, busy_o = 0; pads SHALL be high-Z within the same cycle.
REQ-026 Reset asserted mid-DRIVE or mid-PARK SHALL release pads immediately, with no park cycle.
REQ-027 Reset deassertion SHALL be synchronised by the instantiating level; the first edge after release SHALL sample inputs normally.

Structure
REQ-028 The FSM state enum type and constants DLY_STAGES_MAX=3 and PARK_CYCLES_MAX=15 SHALL live in shared package sd_emmc_pkg.
REQ-029 One sub-module sd_emmc_iobuf (single-lane tri-state pad buffer primitive wrapper: I, T, O, IO) SHALL be instantiated per lane by generate loop.
REQ-030 Illegal parameter values SHALL be rejected by elaboration-time assertion.

Verification
REQ-031 DW=4, DLY=0, PARK=1, push-pull: oe_i=1 with do_i=4'hA for 3 cycles then oe_i=0 -> pads show A from cycle 1 through 3, then F for 1 cycle, then Z; busy_o falls after PARK.
REQ-032 Open-drain, DW=1: do_i toggles 0,1,0 under oe_i=1 -> pad driven 0, Z, 0; no park after oe_i drops.
REQ-033 PARK=3: oe_i reasserted on the 2nd park cycle with do_i=4'h5 -> pads go F, F, 5; no IDLE visit.
REQ-034 DLY=2: oe_i=1 with do_i=4'h3 at cycle 0 -> pads show 3 first at cycle 3; enable and data change on the same edge.
REQ-035 Assert rst_n_i mid-DRIVE (pads=4'hC) -> pads high-Z asynchronously, busy_o=0, di_o=4'hF; after release, oe_i=1 drives normally.
REQ-036 External pull-down on a released lane -> di_o follows 0 with 1-cycle latency while FSM is IDLE.

Source files
------------

// File: rtl/sd_emmc_pkg.sv
// Shared types and limits for the SD/eMMC pad driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_emmc_pkg;

   localparam int DATA_WIDTH_MAX  = 8;
   localparam int DLY_STAGES_MAX  = 3;
   localparam int PARK_CYCLES_MAX = 15;

   // Bus ownership state of the pad driver
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // pads released
      ST_DRIVE = 2'd1,   // pads carry controller data
      ST_PARK  = 2'd2    // pads held all-ones before release
   } io_state_e;

endpackage

// File: rtl/sd_emmc_iobuf.sv
// Single-lane tri-state pad buffer wrapper (I drives, T=1 releases, O samples).
// Latency: combinational.
// Backpressure: none.
module sd_emmc_iobuf (
   input  logic I,
   input  logic T,
   output logic O,
   inout  wire  IO
);

   // A released lane presents high-Z only, so the pad is never fought
   assign IO = T ? 1'bz : I;
   assign O  = IO;

endmodule

// File: rtl/sd_emmc_io_drv.sv
// SD/eMMC CMD/DAT pad driver: push-pull or open-drain, drive-high park before release.
// Latency: 1 + DLY_STAGES cycles from do_i/oe_i sample to pad change; di_o 1 cycle after pad.
// Backpressure: none; oe_i is a level request evaluated every cycle.
module sd_emmc_io_drv
   import sd_emmc_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int DLY_STAGES  = 0,
   parameter int PARK_CYCLES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] do_i,
   input  logic                  oe_i,
   input  logic                  od_mode_i,
   output logic [DATA_WIDTH-1:0] di_o,
   output logic                  busy_o,
   inout  wire  [DATA_WIDTH-1:0] dat_pad
);

   // Elaboration-time parameter range checks
   if (DATA_WIDTH < 1 || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_dw
      $fatal(1, "sd_emmc_io_drv: DATA_WIDTH must be 1..8");
   end
   if (DLY_STAGES < 0 || DLY_STAGES > DLY_STAGES_MAX) begin : g_bad_dly
      $fatal(1, "sd_emmc_io_drv: DLY_STAGES must be 0..3");
   end
   if (PARK_CYCLES < 0 || PARK_CYCLES > PARK_CYCLES_MAX) begin : g_bad_park
      $fatal(1, "sd_emmc_io_drv: PARK_CYCLES must be 0..15");
   end

   localparam logic [3:0] PARK_LD = 4'(PARK_CYCLES);
   localparam bit         PARK_EN = (PARK_CYCLES > 0);

   io_state_e             state_q, state_d;
   logic [3:0]            park_cnt_q, park_cnt_d;
   logic [DATA_WIDTH-1:0] en_d, val_d;
   // Stage 0 is fed by the FSM; the last stage is the output flop at the pads
   logic [DATA_WIDTH-1:0] en_q  [0:DLY_STAGES];
   logic [DATA_WIDTH-1:0] val_q [0:DLY_STAGES];
   logic [DATA_WIDTH-1:0] pad_en, pad_val, pad_in;
   logic [DATA_WIDTH-1:0] di_q;

   // Next-state logic and park down-counter control
   always_comb begin
      state_d    = state_q;
      park_cnt_d = park_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (oe_i) state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (!oe_i) begin
               // Open-drain buses are pulled up externally, so they skip park
               if (!od_mode_i && PARK_EN) begin
                  state_d    = ST_PARK;
                  park_cnt_d = PARK_LD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_PARK: begin
            if (oe_i) begin
               state_d    = ST_DRIVE;
               park_cnt_d = '0;
            end else if (park_cnt_q <= 4'd1) begin
               state_d    = ST_IDLE;
               park_cnt_d = '0;
            end else begin
               park_cnt_d = park_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            park_cnt_d = '0;
         end
      endcase
   end

   // Per-lane enable/value for the state being entered, decoded on the input side
   always_comb begin
      en_d  = '0;
      val_d = '1;
      unique case (state_d)
         ST_DRIVE: begin
            if (od_mode_i) begin
               en_d  = ~do_i;
               val_d = '0;
            end else begin
               en_d  = '1;
               val_d = do_i;
            end
         end
         ST_PARK: begin
            en_d  = '1;
            val_d = '1;
         end
         default: begin
            en_d  = '0;
            val_d = '1;
         end
      endcase
   end

   // FSM state and park counter registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         park_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         park_cnt_q <= park_cnt_d;
      end
   end

   // Delay line: enable and value shift together so they stay aligned at the pads
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int s = 0; s <= DLY_STAGES; s++) begin
            en_q[s]  <= '0;
            val_q[s] <= '1;
         end
      end else begin
         en_q[0]  <= en_d;
         val_q[0] <= val_d;
         for (int s = 1; s <= DLY_STAGES; s++) begin
            en_q[s]  <= en_q[s-1];
            val_q[s] <= val_q[s-1];
         end
      end
   end

   assign pad_en  = en_q[DLY_STAGES];
   assign pad_val = val_q[DLY_STAGES];

   for (genvar n = 0; n < DATA_WIDTH; n++) begin : g_lane
      sd_emmc_iobuf u_iobuf (
         .I  (pad_val[n]),
         .T  (~pad_en[n]),
         .O  (pad_in[n]),
         .IO (dat_pad[n])
      );
   end

   // Pad input sample, taken every cycle regardless of bus ownership
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         di_q <= '1;
      end else begin
         di_q <= pad_in;
      end
   end

   assign di_o   = di_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_emmc_io_drv.sv
// Directed bench for sd_emmc_io_drv across four parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_emmc_io_drv;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   // A: DW4 DLY0 PARK1
   logic       a_oe = 0, a_od = 0;
   logic [3:0] a_do = '0;
   logic [3:0] a_di;
   logic       a_busy;
   wire  [3:0] pad_a;
   logic       ext_en  = 0;
   logic [3:0] ext_val = '0;
   assign pad_a = ext_en ? ext_val : 4'bzzzz;

   // B: DW4 DLY0 PARK3
   logic       b_oe = 0;
   logic [3:0] b_do = '0;
   logic [3:0] b_di;
   logic       b_busy;
   wire  [3:0] pad_b;

   // C: DW4 DLY2 PARK1
   logic       c_oe = 0;
   logic [3:0] c_do = '0;
   logic [3:0] c_di;
   logic       c_busy;
   wire  [3:0] pad_c;

   // D: DW1 open-drain
   logic       d_oe = 0;
   logic [0:0] d_do = '0;
   logic [0:0] d_di;
   logic       d_busy;
   wire  [0:0] pad_d;

   sd_emmc_io_drv #(.DATA_WIDTH(4), .DLY_STAGES(0), .PARK_CYCLES(1)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .do_i(a_do), .oe_i(a_oe), .od_mode_i(a_od),
      .di_o(a_di), .busy_o(a_busy), .dat_pad(pad_a));

   sd_emmc_io_drv #(.DATA_WIDTH(4), .DLY_STAGES(0), .PARK_CYCLES(3)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .do_i(b_do), .oe_i(b_oe), .od_mode_i(1'b0),
      .di_o(b_di), .busy_o(b_busy), .dat_pad(pad_b));

   sd_emmc_io_drv #(.DATA_WIDTH(4), .DLY_STAGES(2), .PARK_CYCLES(1)) dut_c (
      .clk_i(clk), .rst_n_i(rst_n), .do_i(c_do), .oe_i(c_oe), .od_mode_i(1'b0),
      .di_o(c_di), .busy_o(c_busy), .dat_pad(pad_c));

   sd_emmc_io_drv #(.DATA_WIDTH(1), .DLY_STAGES(0), .PARK_CYCLES(1)) dut_d (
      .clk_i(clk), .rst_n_i(rst_n), .do_i(d_do), .oe_i(d_oe), .od_mode_i(1'b1),
      .di_o(d_di), .busy_o(d_busy), .dat_pad(pad_d));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset: asserted between edges, outputs must respond without a clock
      #2 rst_n = 1'b0;
      #1;
      chk("rst_en_a",   32'(dut_a.pad_en), 32'h0);
      chk("rst_busy_a", 32'(a_busy),       32'h0);
      chk("rst_di_a",   32'(a_di),         32'hF);
      chk("rst_en_c",   32'(dut_c.pad_en), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("idle_busy_a", 32'(a_busy), 32'h0);

      // Push-pull drive A for three cycles, one park cycle, then release
      a_oe = 1; a_do = 4'hA;
      step();
      chk("drv1_en",   32'(dut_a.pad_en), 32'hF);
      chk("drv1_pad",  32'(pad_a),        32'hA);
      chk("drv1_busy", 32'(a_busy),       32'h1);
      step();
      chk("drv2_pad",  32'(pad_a),        32'hA);
      chk("drv2_di",   32'(a_di),         32'hA);
      step();
      chk("drv3_pad",  32'(pad_a),        32'hA);
      a_oe = 0;
      step();
      chk("park_en",   32'(dut_a.pad_en), 32'hF);
      chk("park_pad",  32'(pad_a),        32'hF);
      chk("park_busy", 32'(a_busy),       32'h1);
      step();
      chk("rel_en",    32'(dut_a.pad_en), 32'h0);
      chk("rel_busy",  32'(a_busy),       32'h0);

      // External pull on released lanes, sampled one cycle later
      ext_en = 1; ext_val = 4'h0;
      step();
      chk("ext0_di", 32'(a_di), 32'h0);
      ext_val = 4'h5;
      #1;
      chk("ext_lat_di", 32'(a_di), 32'h0);
      step();
      chk("ext5_di", 32'(a_di), 32'h5);
      ext_en = 0;
      step();

      // Open-drain switch mid-drive: only zero bits are driven, no park afterwards
      a_oe = 1; a_od = 0; a_do = 4'hA;
      step();
      chk("pp_en", 32'(dut_a.pad_en), 32'hF);
      a_od = 1;
      step();
      chk("od_en",    32'(dut_a.pad_en),  32'h5);
      chk("od_low",   32'(pad_a & 4'h5),  32'h0);
      chk("od_busy",  32'(a_busy),        32'h1);
      a_oe = 0;
      step();
      chk("od_rel_busy", 32'(a_busy),        32'h0);
      chk("od_rel_en",   32'(dut_a.pad_en),  32'h0);
      a_od = 0;

      // Open-drain single lane: 0,1,0
      d_oe = 1; d_do = 1'b0;
      step();
      chk("d0_en",   32'(dut_d.pad_en), 32'h1);
      chk("d0_pad",  32'(pad_d),        32'h0);
      chk("d0_busy", 32'(d_busy),       32'h1);
      d_do = 1'b1;
      step();
      chk("d1_en",   32'(dut_d.pad_en), 32'h0);
      d_do = 1'b0;
      step();
      chk("d2_en",   32'(dut_d.pad_en), 32'h1);
      chk("d2_pad",  32'(pad_d),        32'h0);
      d_oe = 0;
      step();
      chk("d_nopark_en",   32'(dut_d.pad_en), 32'h0);
      chk("d_nopark_busy", 32'(d_busy),       32'h0);

      // Park abort on second park cycle, then a full three-cycle park
      b_oe = 1; b_do = 4'h9;
      step();
      chk("b_drv_pad", 32'(pad_b), 32'h9);
      b_oe = 0;
      step();
      chk("b_park1_pad", 32'(pad_b), 32'hF);
      step();
      chk("b_park2_pad", 32'(pad_b), 32'hF);
      chk("b_park2_en",  32'(dut_b.pad_en), 32'hF);
      b_oe = 1; b_do = 4'h5;
      step();
      chk("b_abort_pad",  32'(pad_b),  32'h5);
      chk("b_abort_busy", 32'(b_busy), 32'h1);
      b_oe = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("b_full_park%0d_pad", i), 32'(pad_b),  32'hF);
         chk($sformatf("b_full_park%0d_en",  i), 32'(dut_b.pad_en), 32'hF);
         chk($sformatf("b_full_park%0d_busy", i), 32'(b_busy), 32'h1);
      end
      step();
      chk("b_rel_en",   32'(dut_b.pad_en), 32'h0);
      chk("b_rel_busy", 32'(b_busy),       32'h0);

      // Two extra delay stages: pad changes on the third edge
      c_oe = 1; c_do = 4'h3;
      step();
      c_oe = 0;
      chk("c1_en",   32'(dut_c.pad_en), 32'h0);
      chk("c1_busy", 32'(c_busy),       32'h1);
      step();
      chk("c2_en",   32'(dut_c.pad_en), 32'h0);
      chk("c2_busy", 32'(c_busy),       32'h1);
      step();
      chk("c3_en",   32'(dut_c.pad_en), 32'hF);
      chk("c3_pad",  32'(pad_c),        32'h3);
      chk("c3_busy", 32'(c_busy),       32'h0);
      step();
      chk("c4_en",   32'(dut_c.pad_en), 32'hF);
      chk("c4_pad",  32'(pad_c),        32'hF);
      step();
      chk("c5_en",   32'(dut_c.pad_en), 32'h0);

      // Reset mid-drive releases pads at once, then normal drive resumes
      a_oe = 1; a_do = 4'hC;
      step();
      chk("a_pre_rst_pad", 32'(pad_a), 32'hC);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en",   32'(dut_a.pad_en), 32'h0);
      chk("mid_rst_busy", 32'(a_busy),       32'h0);
      chk("mid_rst_di",   32'(a_di),         32'hF);
      step();
      chk("mid_rst_hold_en", 32'(dut_a.pad_en), 32'h0);
      rst_n = 1'b1;
      step();
      chk("post_rst_en",   32'(dut_a.pad_en), 32'hF);
      chk("post_rst_pad",  32'(pad_a),        32'hC);
      chk("post_rst_busy", 32'(a_busy),       32'h1);
      a_oe = 0;
      step();
      step();
      chk("post_rst_rel", 32'(dut_a.pad_en), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
